fastica_seq_controller: RTL
===========================

Name: fastica_seq_controller

Overview:
Parametrised successor to the single-pass FastICA top controller. It sequences the orthogonalisation, normalisation, FastICA update, error/convergence, multiply and memory write-back stages. It adds symmetric or deflation mode, a per-component loop, an iteration limit with timeout, address generation for the write-back, and a held done state. It sits at the FastICA top level and drives the sub-block go/en strobes from the shared clk_fastica domain.

Parameters:
NUM_COMP, 2, number of independent components; deflation mode loops this many times.
MAX_ITER, 64, maximum ORTH..ERR iterations per component before forced exit.
DELAY_CYC, 1, idle cycles between IDLE and the first ORTH (range 1..255).
MEM_DEPTH, 128, number of write-back cycles/addresses in MEM.
ADDR_W, 14, width of address_sel_mem1; must satisfy 2^ADDR_W >= MEM_DEPTH.
ITER_W, 8, width of iter_cnt; must satisfy 2^ITER_W >= MAX_ITER.

Ports:
clk_fastica  in  1  block clock, rising edge.
go_fastica  in  1  asynchronous active-low reset; low = held in reset, high = run.
deflate  in  1  mode select: 1 deflation, 0 symmetric; sampled in IDLE only.
symm_busy  in  1  orthogonaliser busy.
fast_busy  in  1  FastICA update busy.
error_busy  in  1  error calculator busy.
isConverge  in  1  convergence flag from the error calculator.
fastica_busy  out  1  high in every state except IDLE and DONE.
go_symm  out  1  orthogonaliser start level.
en_norm  out  1  normaliser enable.
go_fast  out  1  FastICA update start level.
en_error  out  1  error calculator enable.
en_mul1  out  1  output multiplier enable.
en_mem1  out  1  output memory enable.
rw  out  1  memory write strobe; 1 only in MEM.
address_sel_mem1  out  ADDR_W  write address.
comp_idx  out  clog2(NUM_COMP) (min 1)  current component.
iter_cnt  out  ITER_W  iterations completed for the current component.
timeout  out  1  sticky; set when any component exits via MAX_ITER.
done  out  1  high in DONE.

Behaviour:
- Reset (go_fastica low, async): state=IDLE, cnt=0, iter_cnt=0, comp_idx=0, timeout=0, mode register=0. All outputs are 0.
- cnt is the in-state cycle counter. It clears on every state change and increments while the state is held.
- Outputs are a Moore decode of state. Default for every strobe is 0; only the strobes listed per state are 1.
- IDLE, 1 cycle: latch deflate, then go to DELAY.
- DELAY: no strobes. After DELAY_CYC cycles go to ORTH.
- ORTH: go_symm=1. Go to NORM when cnt>=1 and ~symm_busy. The first cycle ignores busy.
- NORM, 1 cycle: en_norm=1, then go to FAST.
- FAST: go_fast=1. Go to ERR_DLY when cnt>=1 and ~fast_busy.
- ERR_DLY, 1 cycle: go_fast=1 and en_error=1, then go to ERR.
- ERR: en_error=1. Priority order:
  (a) isConverge=1 on any cycle: take the converged path.
  (b) cnt>=1, ~error_busy and iter_cnt==MAX_ITER-1: set timeout, take the converged path.
  (c) cnt>=1 and ~error_busy: iter_cnt+=1, go to ORTH.
- Converged path: if mode=deflation and comp_idx<NUM_COMP-1, then comp_idx+=1, iter_cnt=0, go to ORTH. Otherwise go to MUL.
- MUL, 1 cycle: en_mul1=1, then go to MEM.
- MEM: en_mul1=1, en_mem1=1, rw=1, address_sel_mem1=cnt zero-extended. Addresses run 0..MEM_DEPTH-1, exactly MEM_DEPTH cycles, then go to DONE.
- address_sel_mem1 is 0 outside MEM.
- DONE: done=1 and all strobes 0. iter_cnt, comp_idx and timeout hold. The block remains in DONE until go_fastica is low; there is no auto-restart.
- Symmetric mode (mode=0): comp_idx stays 0.
- A change on deflate after IDLE is ignored.
- go_fastica falling mid-operation (e.g. mid-MEM) aborts immediately to reset values; the write sequence is not completed.
- Busy inputs that are already low on the first state cycle do not cause early exit.

Decomposition:
- Shared fastica_pkg holds:
  - state encoding localparams (IDLE, DELAY, ORTH, NORM, FAST, ERR_DLY, ERR, MUL, MEM, DONE; 4 bits);
  - a clog2 function;
  - the parameter legality checks.
- One natural sub-module, fastica_cycle_counter: a clear/increment counter with a terminal-count compare, used for cnt. The iteration and component counters stay inline.

Test Plan:
- Symmetric, busys pulse 3 cycles, isConverge=1 on the first ERR -> one pass ORTH..ERR, then MUL. MEM drives addresses 0..127 with rw=1 for 128 cycles, then done=1, fastica_busy=0, iter_cnt=0, timeout=0.
- Deflation, NUM_COMP=3, converge on the 2nd iteration of each component -> comp_idx steps 0,1,2, iter_cnt=1 at each exit, a single MEM phase, done=1.
- MAX_ITER=4, isConverge never set -> 4 ORTH entries, then timeout=1, iter_cnt=3, MUL and MEM follow.
- symm_busy held high 20 cycles -> go_symm stays 1 for 21 cycles; NORM is entered exactly one cycle after symm_busy falls.
- go_fastica driven low at MEM address 50 -> all outputs 0 asynchronously. After release: IDLE, DELAY, then ORTH with comp_idx=0.
- deflate toggled during ORTH in symmetric mode -> comp_idx stays 0; the run completes with one component.

Source files
------------

// File: rtl/fastica_pkg.sv
// Shared definitions for the FastICA sequencer: state encoding, clog2 and parameter legality.
package fastica_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_DELAY   = 4'd1,
        ST_ORTH    = 4'd2,
        ST_NORM    = 4'd3,
        ST_FAST    = 4'd4,
        ST_ERR_DLY = 4'd5,
        ST_ERR     = 4'd6,
        ST_MUL     = 4'd7,
        ST_MEM     = 4'd8,
        ST_DONE    = 4'd9
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (longint p = 1; p < longint'(v); p = p * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A single component still needs a one-bit index port.
    function automatic int comp_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic bit params_ok(input int num_comp, input int max_iter, input int delay_cyc,
                                     input int mem_depth, input int addr_w, input int iter_w);
        return (num_comp >= 1) && (max_iter >= 1) &&
               (delay_cyc >= 1) && (delay_cyc <= 255) && (mem_depth >= 1) &&
               (addr_w >= 1) && (addr_w <= 62) && (iter_w >= 1) && (iter_w <= 62) &&
               ((longint'(1) << addr_w) >= longint'(mem_depth)) &&
               ((longint'(1) << iter_w) >= longint'(max_iter));
    endfunction

endpackage

// File: rtl/fastica_cycle_counter.sv
// In-state cycle counter: clears on request, otherwise counts up and saturates at all-ones.
// term_hit_o is a same-cycle compare of the current count against term_i.
module fastica_cycle_counter
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic         term_hit_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Saturating so a very long busy wait can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign term_hit_o = (cnt_q == term_i);

endmodule

// File: rtl/fastica_seq_controller.sv
// FastICA top sequencer: ORTH..ERR loop per component, then MUL and MEM write-back, then held DONE.
// Strobes are registered decodes of the next state; busy inputs are only honoured from a state's second cycle.
module fastica_seq_controller
    import fastica_pkg::*;
#(
    parameter int NUM_COMP  = 2,
    parameter int MAX_ITER  = 64,
    parameter int DELAY_CYC = 1,
    parameter int MEM_DEPTH = 128,
    parameter int ADDR_W    = 14,
    parameter int ITER_W    = 8,
    parameter int COMP_W    = comp_width(NUM_COMP)
) (
    input  logic              clk_fastica,
    input  logic              go_fastica,
    input  logic              deflate,
    input  logic              symm_busy,
    input  logic              fast_busy,
    input  logic              error_busy,
    input  logic              isConverge,
    output logic              fastica_busy,
    output logic              go_symm,
    output logic              en_norm,
    output logic              go_fast,
    output logic              en_error,
    output logic              en_mul1,
    output logic              en_mem1,
    output logic              rw,
    output logic [ADDR_W-1:0] address_sel_mem1,
    output logic [COMP_W-1:0] comp_idx,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              timeout,
    output logic              done
);

    localparam int CNT_W = clog2((MEM_DEPTH > 256) ? MEM_DEPTH : 256);

    if (!params_ok(NUM_COMP, MAX_ITER, DELAY_CYC, MEM_DEPTH, ADDR_W, ITER_W)) begin : g_bad_params
        $error("fastica_seq_controller: illegal parameter set");
    end

    state_e             state_q, state_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic [COMP_W-1:0]  comp_q, comp_d;
    logic               timeout_q, timeout_d;
    logic               mode_q;
    logic               converged;

    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_term;
    logic               cnt_hit;
    logic               cnt_clr;
    logic               cnt_nz;

    logic               busy_q, go_symm_q, en_norm_q, go_fast_q, en_error_q;
    logic               en_mul1_q, en_mem1_q, rw_q, done_q;
    logic [ADDR_W-1:0]  addr_q;

    assign cnt_clr  = (state_d != state_q);
    assign cnt_nz   = (cnt != '0);
    assign cnt_term = (state_q == ST_MEM) ? CNT_W'(MEM_DEPTH - 1) : CNT_W'(DELAY_CYC - 1);

    fastica_cycle_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clk_i      (clk_fastica),
        .rst_ni     (go_fastica),
        .clr_i      (cnt_clr),
        .term_i     (cnt_term),
        .cnt_o      (cnt),
        .term_hit_o (cnt_hit)
    );

    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        comp_d    = comp_q;
        timeout_d = timeout_q;
        converged = 1'b0;
        case (state_q)
            ST_IDLE:    state_d = ST_DELAY;
            ST_DELAY:   if (cnt_hit) state_d = ST_ORTH;
            ST_ORTH:    if (cnt_nz && !symm_busy) state_d = ST_NORM;
            ST_NORM:    state_d = ST_FAST;
            ST_FAST:    if (cnt_nz && !fast_busy) state_d = ST_ERR_DLY;
            ST_ERR_DLY: state_d = ST_ERR;
            ST_ERR: begin
                // Convergence wins even on the first cycle; the iteration limit is a forced convergence.
                if (isConverge) begin
                    converged = 1'b1;
                end else if (cnt_nz && !error_busy) begin
                    if (iter_q == ITER_W'(MAX_ITER - 1)) begin
                        timeout_d = 1'b1;
                        converged = 1'b1;
                    end else begin
                        iter_d  = iter_q + ITER_W'(1);
                        state_d = ST_ORTH;
                    end
                end
            end
            ST_MUL:     state_d = ST_MEM;
            ST_MEM:     if (cnt_hit) state_d = ST_DONE;
            ST_DONE:    state_d = ST_DONE;
            default:    state_d = ST_IDLE;
        endcase

        if (converged) begin
            if (mode_q && (comp_q < COMP_W'(NUM_COMP - 1))) begin
                comp_d  = comp_q + COMP_W'(1);
                iter_d  = '0;
                state_d = ST_ORTH;
            end else begin
                state_d = ST_MUL;
            end
        end
    end

    always_ff @(posedge clk_fastica or negedge go_fastica) begin
        if (!go_fastica) begin
            state_q    <= ST_IDLE;
            iter_q     <= '0;
            comp_q     <= '0;
            timeout_q  <= 1'b0;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            go_symm_q  <= 1'b0;
            en_norm_q  <= 1'b0;
            go_fast_q  <= 1'b0;
            en_error_q <= 1'b0;
            en_mul1_q  <= 1'b0;
            en_mem1_q  <= 1'b0;
            rw_q       <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            comp_q     <= comp_d;
            timeout_q  <= timeout_d;
            if (state_q == ST_IDLE) begin
                mode_q <= deflate;
            end
            busy_q     <= (state_d != ST_IDLE) && (state_d != ST_DONE);
            go_symm_q  <= (state_d == ST_ORTH);
            en_norm_q  <= (state_d == ST_NORM);
            go_fast_q  <= (state_d == ST_FAST) || (state_d == ST_ERR_DLY);
            en_error_q <= (state_d == ST_ERR_DLY) || (state_d == ST_ERR);
            en_mul1_q  <= (state_d == ST_MUL) || (state_d == ST_MEM);
            en_mem1_q  <= (state_d == ST_MEM);
            rw_q       <= (state_d == ST_MEM);
            done_q     <= (state_d == ST_DONE);
            // Tracks the in-state count while in MEM, zero everywhere else.
            addr_q     <= ((state_d == ST_MEM) && (state_q == ST_MEM)) ? addr_q + ADDR_W'(1) : '0;
        end
    end

    assign fastica_busy     = busy_q;
    assign go_symm          = go_symm_q;
    assign en_norm          = en_norm_q;
    assign go_fast          = go_fast_q;
    assign en_error         = en_error_q;
    assign en_mul1          = en_mul1_q;
    assign en_mem1          = en_mem1_q;
    assign rw               = rw_q;
    assign address_sel_mem1 = addr_q;
    assign comp_idx         = comp_q;
    assign iter_cnt         = iter_q;
    assign timeout          = timeout_q;
    assign done             = done_q;

endmodule
